ex_muldiv_ctrl: RTL and testbench
=================================

Name: ex_muldiv_ctrl

Overview:
Multi-cycle sequencer for the RV32M instructions in the EX stage, alongside the single-cycle ALU/comparator path. Accepts one M-extension op per handshake and runs a 32-iteration shift-add multiply or restoring divide on operand magnitudes, with sign fix-up at the end. Stalls the pipeline while busy and returns one 32-bit result with a one-cycle valid pulse.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  EX holds an M-op
in_ready  out  1  controller can accept (state IDLE)
in_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
in_a  in  32  rs1 operand
in_b  in  32  rs2 operand
flush  in  1  pipeline flush; aborts in-flight op
stall  out  1  freeze IF/ID/EX
out_valid  out  1  result valid, single-cycle pulse
out_result  out  32  result

Behaviour:
- Clocking: one clock `clk`; reset `rst_n` is asynchronous and active-low. On reset: state IDLE; counter 0; internal accumulators 0; out_valid 0; out_result 0; in_ready 1; stall 0.
- Handshake: op accepted on a rising edge where in_valid & in_ready & !flush. in_ready = (state==IDLE).
- States:
  - IDLE -> MUL (op 0-3) or DIV (op 4-7) on accept.
  - IDLE -> DONE directly for the divide special cases below.
  - MUL/DIV iterate exactly 32 cycles, counter 0..31, then -> DONE.
  - DONE lasts one cycle, then -> IDLE.
- Operand prep on accept:
  - Signedness: a is signed for ops 1, 2, 4, 6; b is signed for ops 1, 4, 6.
  - Magnitudes are |a| and |b|.
  - Product sign = sa^sb. Quotient sign = sa^sb. Remainder sign = sa.
- MUL:
  - 64-bit acc.
  - Each cycle: if multiplier LSB, add multiplicand to upper 33 bits; shift right 1.
  - On DONE, negate the 64-bit product if its sign bit is set.
  - Op 0 returns bits [31:0]; ops 1-3 return bits [63:32].
- DIV (restoring):
  - Each cycle: shift {rem,quo} left 1; trial = rem - |b|; if non-negative, rem = trial and quo LSB = 1.
  - Final quotient/remainder negated per their signs.
- Special cases, 1-cycle path (IDLE->DONE):
  - b==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> a.
  - Signed overflow (a==0x80000000, b==0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- Latency: out_valid high in the cycle after the 33rd edge following acceptance (special cases: the cycle after the accept edge).
- out_result is registered on entering DONE and holds until the next DONE.
- stall = (in_valid & state==IDLE) | (state==MUL) | (state==DIV). Low in DONE, so EX advances when out_valid is high.
- Flush:
  - In MUL/DIV: next state IDLE, no out_valid.
  - In DONE: out_valid still pulses; consumer discards it.
  - flush with in_valid in IDLE: not accepted.
- in_a/in_b/in_op are sampled only at accept; later changes are ignored.
- Mid-operation reset: immediate return to reset values.

Optional Feature:
- Macro: MULDIV_FASTMUL_EN.
- Defined: ops 0-3 compute the signed 33x33 product combinationally at accept and go IDLE->DONE, so latency is 1 cycle; DIV path is unchanged.
- Undefined: iterative MUL as above (33-cycle latency).
- The interface is identical in both builds.

Decomposition:
- Shared package (param.v):
  - funct3 M-op encodings: MUL..REMU
  - state encodings IDLE/MUL/DIV/DONE (2 bits)
  - XLEN
  - special-case constants: all-ones, INT_MIN
- Sub-module muldiv_step: combinational single-iteration unit. Inputs: mode, acc/rem, quo, operand. Outputs: next values. The controller owns FSM, counter, sign fix-up and registers.

Test Plan:
1. Reset then idle -> in_ready=1, stall=0, out_valid=0.
2. MUL a=7, b=-3 (0xFFFFFFFD), op 0 -> out_result 0xFFFFFFEB; out_valid exactly one cycle, 33 cycles after accept; stall high throughout until then.
3. MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=-1, b=2 -> 0xFFFFFFFF.
4. DIV a=-7, b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
5. DIV b=0, a=5 -> 0xFFFFFFFF after 1 cycle; REM b=0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM same -> 0.
6. Flush at iteration 10 of a DIV -> IDLE next cycle, no out_valid, stall drops. Back-to-back MUL then DIV accepted the cycle after DONE -> both results correct. Assert rst_n low mid-MUL -> outputs at reset values immediately.

Source files
------------

// File: rtl/ex_muldiv_ctrl_pkg.sv
// ex_muldiv_ctrl_pkg: shared widths, M-op funct3 and FSM state encodings, divide special-case constants
package ex_muldiv_ctrl_pkg;
  localparam int XLEN = 32;
  localparam int CNT_W = 5;
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [2:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU} op_e;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// ex_muldiv_ctrl_if: EX-stage M-op request/result bundle; master is the pipeline, slave is the sequencer
interface ex_muldiv_ctrl_if;
  import ex_muldiv_ctrl_pkg::*;
  logic in_valid, in_ready, flush, stall, out_valid;
  logic [2:0] in_op;
  logic [XLEN-1:0] in_a, in_b, out_result;
  modport master (output in_valid, in_op, in_a, in_b, flush, input in_ready, stall, out_valid, out_result);
  modport slave (input in_valid, in_op, in_a, in_b, flush, output in_ready, stall, out_valid, out_result);
endinterface

// File: rtl/ex_muldiv_ctrl_step.sv
// ex_muldiv_ctrl_step: one shift-add multiply (mode 0) or restoring divide (mode 1) iteration
module ex_muldiv_ctrl_step import ex_muldiv_ctrl_pkg::*; (
  input  logic            mode,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);
  logic [XLEN:0] sum, sh;
  logic [XLEN-1:0] diff;
  logic ge;
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    sh = {hi, lo[XLEN-1]};
    ge = sh >= {1'b0, opnd};
    // remainder stays below the divisor, so the difference always fits XLEN bits
    diff = sh[XLEN-1:0] - opnd;
    hi_nxt = mode ? (ge ? diff : sh[XLEN-1:0]) : sum[XLEN:1];
    lo_nxt = mode ? {lo[XLEN-2:0], ge} : {sum[0], lo[XLEN-1:1]};
  end
endmodule

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: RV32M EX-stage sequencer (32-step multiply / restoring divide).
// Define MULDIV_FASTMUL_EN for a single-cycle combinational multiply path.
module ex_muldiv_ctrl import ex_muldiv_ctrl_pkg::*; (
  input logic clk,
  input logic rst_n,
  ex_muldiv_ctrl_if.slave bus
);
  state_e state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] hi, lo, opnd, hi_nxt, lo_nxt, ma, mb, spec_res, acc_res, div_val, div_res, mul_res;
  logic [2*XLEN-1:0] prod;
  logic [2:0] op_r;
  logic neg_r, accept, is_div, sa, sb, neg, special, go_done, busy;
  assign is_div = bus.in_op[2];
  assign sa = bus.in_a[XLEN-1] & (bus.in_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign sb = bus.in_b[XLEN-1] & (bus.in_op inside {OP_MULH, OP_DIV, OP_REM});
  assign neg = (is_div & bus.in_op[1]) ? sa : sa ^ sb;
  assign ma = sa ? -bus.in_a : bus.in_a;
  assign mb = sb ? -bus.in_b : bus.in_b;
  assign special = is_div & ((bus.in_b == '0) | (~bus.in_op[0] & (bus.in_a == INT_MIN) & (bus.in_b == ALL_ONES)));
  assign spec_res = (bus.in_b == '0) ? (bus.in_op[1] ? bus.in_a : ALL_ONES) : (bus.in_op[1] ? '0 : INT_MIN);
`ifdef MULDIV_FASTMUL_EN
  logic signed [2*XLEN-1:0] fa, fb, fprod;
  assign fa = {{XLEN{sa}}, bus.in_a};
  assign fb = {{XLEN{sb}}, bus.in_b};
  assign fprod = fa * fb;
  assign go_done = special | ~is_div;
  assign acc_res = special ? spec_res : (bus.in_op == OP_MUL ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN]);
`else
  assign go_done = special;
  assign acc_res = spec_res;
`endif
  assign busy = (state == S_MUL) | (state == S_DIV);
  assign accept = bus.in_valid & (state == S_IDLE) & ~bus.flush;
  assign bus.in_ready = state == S_IDLE;
  assign bus.stall = (bus.in_valid & (state == S_IDLE)) | busy;
  assign bus.out_valid = state == S_DONE;
  ex_muldiv_ctrl_step u_step (.mode(state == S_DIV), .hi(hi), .lo(lo), .opnd(opnd), .hi_nxt(hi_nxt), .lo_nxt(lo_nxt));
  assign prod = neg_r ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
  assign mul_res = (op_r == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign div_val = op_r[1] ? hi_nxt : lo_nxt;
  assign div_res = neg_r ? -div_val : div_val;
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = go_done ? S_DONE : (is_div ? S_DIV : S_MUL);
      S_MUL, S_DIV: state_nxt = bus.flush ? S_IDLE : (&cnt ? S_DONE : state);
      default: state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      opnd <= '0;
      op_r <= '0;
      neg_r <= 1'b0;
      bus.out_result <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= '0;
        op_r <= bus.in_op;
        neg_r <= neg;
        hi <= '0;
        lo <= is_div ? ma : mb;
        opnd <= is_div ? mb : ma;
        if (go_done) bus.out_result <= acc_res;
      end else if (busy) begin
        cnt <= cnt + 1'b1;
        hi <= hi_nxt;
        lo <= lo_nxt;
        if (state_nxt == S_DONE) bus.out_result <= (state == S_DIV) ? div_res : mul_res;
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb_ex_muldiv_ctrl: directed vector table, corner sequences and random ops against an arithmetic model
module tb_ex_muldiv_ctrl;
`ifdef MULDIV_FASTMUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  int n_pass = 0, n_total = 0;
  ex_muldiv_ctrl_if bus();
  ex_muldiv_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {logic [2:0] op; logic [31:0] a, b, exp;} vec_t;
  vec_t tbl[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0, 3'd1: r = sa * sb;
      3'd2: r = sa * ub;
      3'd3: r = ua * ub;
      default: r = 64'd0;
    endcase
    if (op == 3'd0) return r[31:0];
    if (op < 3'd4) return r[63:32];
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      3'd4: r = sa / sb;
      3'd5: r = ua / ub;
      3'd6: r = sa % sb;
      default: r = ua % ub;
    endcase
    return r[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) return (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 0 : 32;
    return FAST ? 0 : 32;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input string nm);
    int lat;
    bit sbad;
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_a = a;
    bus.in_b = b;
    #1 chk({nm, " req"}, {bus.in_ready, bus.stall}, 2'b11);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a = $urandom;
    bus.in_b = $urandom;
    bus.in_op = 3'($urandom);
    lat = 0;
    sbad = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (!bus.stall) sbad = 1'b1;
      @(posedge clk);
      #1 lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(ref_lat(op, a, b)));
    chk({nm, " result"}, bus.out_result, exp);
    chk({nm, " stall"}, {sbad, bus.stall}, 2'b00);
    @(posedge clk);
    #1 chk({nm, " pulse/hold"}, {bus.out_valid, bus.out_result}, {1'b0, exp});
  endtask

  initial begin
    bit bad;
    logic [2:0] op;
    logic [31:0] a, b;
    tbl[0]  = '{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    tbl[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    tbl[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF};
    tbl[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
    tbl[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
    tbl[6]  = '{3'd5, 32'd100, 32'd7, 32'd14};
    tbl[7]  = '{3'd7, 32'd100, 32'd7, 32'd2};
    tbl[8]  = '{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF};
    tbl[9]  = '{3'd6, 32'd5, 32'd0, 32'd5};
    tbl[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    tbl[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    tbl[12] = '{3'd5, 32'd9, 32'd0, 32'hFFFF_FFFF};
    tbl[13] = '{3'd7, 32'd9, 32'd0, 32'd9};
    bus.in_valid = 1'b0;
    bus.in_op = '0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset state", {bus.in_ready, bus.stall, bus.out_valid, bus.out_result}, {3'b100, 32'd0});
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("idle", {bus.in_ready, bus.stall, bus.out_valid}, 3'b100);
    foreach (tbl[i]) run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("vec%0d", i));
    // abort a divide ten iterations in
    bus.in_valid = 1'b1;
    bus.in_op = 3'd4;
    bus.in_a = 32'd1000;
    bus.in_b = 32'd7;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    chk("flush to idle", {bus.in_ready, bus.stall, bus.out_valid}, 3'b100);
    bad = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bus.out_valid) bad = 1'b1;
    end
    chk("flush no valid", bad, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_op = 3'd4;
    bus.in_a = 32'd5;
    bus.in_b = 32'd0;
    bus.flush = 1'b1;
    @(posedge clk);
    #1 chk("flush blocks accept", {bus.in_ready, bus.out_valid}, 2'b10);
    bus.flush = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bus.flush = 1'b1;
    #1 chk("flush in done", {bus.out_valid, bus.out_result}, {1'b1, 32'hFFFF_FFFF});
    @(posedge clk);
    #1 bus.flush = 1'b0;
    chk("after done flush", {bus.in_ready, bus.out_valid}, 2'b10);
    bus.in_valid = 1'b1;
    bus.in_op = 3'd0;
    bus.in_a = 32'd5;
    bus.in_b = 32'd6;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("mid-op reset", {bus.in_ready, bus.stall, bus.out_valid, bus.out_result}, {3'b100, 32'd0});
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom);
      a = pick();
      b = pick();
      run_op(op, a, b, ref_res(op, a, b), $sformatf("rnd%0d op%0d", i, op));
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
